// File: rtl/i2c_arb.sv
// Two-port round-robin arbiter in front of a single I2C byte driver.
// Optional BUSY watchdog with driver abort is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arb #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_wr,
    input  logic        req0_addr_num,
    input  logic [15:0] req0_addr,
    input  logic [7:0]  req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [7:0]  req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_wr,
    input  logic        req1_addr_num,
    input  logic [15:0] req1_addr,
    input  logic [7:0]  req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [7:0]  req1_rdata,
    output logic        req1_err,
    output logic        busy,
    output logic        drv_start,
    output logic        drv_wr_en,
    output logic        drv_rd_en,
    output logic        drv_addr_num,
    output logic [15:0] drv_byte_addr,
    output logic [7:0]  drv_wr_data,
    input  logic        drv_end,
    input  logic [7:0]  drv_rd_data,
    output logic        drv_abort
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_grant;
    logic        w_grant;
    logic        r_last_grant;
    logic        w_last_grant;

    logic        r_ready0, w_ready0;
    logic        r_ready1, w_ready1;
    logic        r_done0, w_done0;
    logic        r_done1, w_done1;
    logic        r_err0, w_err0;
    logic        r_err1, w_err1;
    logic [7:0]  r_rdata0, w_rdata0;
    logic [7:0]  r_rdata1, w_rdata1;
    logic        r_busy, w_busy;
    logic        r_start, w_start;
    logic        r_abort, w_abort;
    logic        r_wr_en, w_wr_en;
    logic        r_rd_en, w_rd_en;
    logic        r_addr_num, w_addr_num;
    logic [15:0] r_byte_addr, w_byte_addr;
    logic [7:0]  r_wr_data, w_wr_data;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] r_cnt, w_cnt;
`else
    logic        w_unused;
    assign w_unused = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_grant      = r_grant;
        w_last_grant = r_last_grant;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        w_done0      = 1'b0;
        w_done1      = 1'b0;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        w_err0       = r_err0;
        w_err1       = r_err1;
        w_rdata0     = r_rdata0;
        w_rdata1     = r_rdata1;
        w_wr_en      = r_wr_en;
        w_rd_en      = r_rd_en;
        w_addr_num   = r_addr_num;
        w_byte_addr  = r_byte_addr;
        w_wr_data    = r_wr_data;
`ifdef I2C_ARB_TIMEOUT_EN
        w_cnt        = r_cnt;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (req0_valid | req1_valid) begin
                    // On a tie the port that did not win last time goes next
                    w_grant      = (req0_valid & req1_valid) ?
                                   ~r_last_grant : req1_valid;
                    w_last_grant = w_grant;
                    w_next       = S_ISSUE;
                    w_ready0     = ~w_grant;
                    w_ready1     = w_grant;
                    w_start      = 1'b1;
                    w_wr_en      = w_grant ? req1_wr : req0_wr;
                    w_rd_en      = ~w_wr_en;
                    w_addr_num   = w_grant ? req1_addr_num : req0_addr_num;
                    w_byte_addr  = w_grant ? req1_addr : req0_addr;
                    w_wr_data    = w_grant ? req1_wdata : req0_wdata;
                end
            end
            S_ISSUE: begin
                w_next = S_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                w_cnt  = 16'd0;
`endif
            end
            S_BUSY: begin
                if (drv_end) begin
                    w_next  = S_DONE;
                    w_done0 = ~r_grant;
                    w_done1 = r_grant;
                    if (r_grant) begin
                        w_err1 = 1'b0;
                        if (r_rd_en) w_rdata1 = drv_rd_data;
                    end else begin
                        w_err0 = 1'b0;
                        if (r_rd_en) w_rdata0 = drv_rd_data;
                    end
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (r_cnt == TIMEOUT_CYC - 16'd1) begin
                    w_next  = S_DONE;
                    w_done0 = ~r_grant;
                    w_done1 = r_grant;
                    w_abort = 1'b1;
                    if (r_grant) w_err1 = 1'b1;
                    else         w_err0 = 1'b1;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
`endif
            end
            S_DONE: begin
                w_next      = S_IDLE;
                w_wr_en     = 1'b0;
                w_rd_en     = 1'b0;
                w_addr_num  = 1'b0;
                w_byte_addr = 16'd0;
                w_wr_data   = 8'd0;
            end
            default: w_next = S_IDLE;
        endcase
        w_busy = (w_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_ready0     <= 1'b0;
            r_ready1     <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rdata0     <= 8'd0;
            r_rdata1     <= 8'd0;
            r_busy       <= 1'b0;
            r_start      <= 1'b0;
            r_abort      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_addr_num   <= 1'b0;
            r_byte_addr  <= 16'd0;
            r_wr_data    <= 8'd0;
        end else begin
            r_grant      <= w_grant;
            r_last_grant <= w_last_grant;
            r_ready0     <= w_ready0;
            r_ready1     <= w_ready1;
            r_done0      <= w_done0;
            r_done1      <= w_done1;
            r_err0       <= w_err0;
            r_err1       <= w_err1;
            r_rdata0     <= w_rdata0;
            r_rdata1     <= w_rdata1;
            r_busy       <= w_busy;
            r_start      <= w_start;
            r_abort      <= w_abort;
            r_wr_en      <= w_wr_en;
            r_rd_en      <= w_rd_en;
            r_addr_num   <= w_addr_num;
            r_byte_addr  <= w_byte_addr;
            r_wr_data    <= w_wr_data;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= w_cnt;
        end
    end
`endif

    assign req0_ready    = r_ready0;
    assign req1_ready    = r_ready1;
    assign req0_done     = r_done0;
    assign req1_done     = r_done1;
    assign req0_err      = r_err0;
    assign req1_err      = r_err1;
    assign req0_rdata    = r_rdata0;
    assign req1_rdata    = r_rdata1;
    assign busy          = r_busy;
    assign drv_start     = r_start;
    assign drv_abort     = r_abort;
    assign drv_wr_en     = r_wr_en;
    assign drv_rd_en     = r_rd_en;
    assign drv_addr_num  = r_addr_num;
    assign drv_byte_addr = r_byte_addr;
    assign drv_wr_data   = r_wr_data;

endmodule
